// File: rtl/call_pkg.sv
// ----------------------------------------------------------------------------
// call_pkg
// Shared definitions for the call-control layer: call state codes reported to
// the UI, UI command codes, network message types and the broadcast address.
// Imported by call_controller, block_list and user_interface.
// ----------------------------------------------------------------------------
package call_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INCOMING  = 3'd1,
        ST_OUTGOING  = 3'd2,
        ST_BUSY      = 3'd3,
        ST_CALL_WAIT = 3'd4,
        ST_INIT      = 3'd5
    } state_t;

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_INIT    = 3'd1;
    localparam logic [2:0] CMD_DIAL    = 3'd2;
    localparam logic [2:0] CMD_ACCEPT  = 3'd3;
    localparam logic [2:0] CMD_REJECT  = 3'd4;
    localparam logic [2:0] CMD_END     = 3'd5;
    localparam logic [2:0] CMD_BLK_ADD = 3'd6;
    localparam logic [2:0] CMD_BLK_CLR = 3'd7;

    localparam logic [2:0] MSG_INIT    = 3'd1;
    localparam logic [2:0] MSG_RING    = 3'd2;
    localparam logic [2:0] MSG_ACK     = 3'd3;
    localparam logic [2:0] MSG_NACK    = 3'd4;
    localparam logic [2:0] MSG_HANGUP  = 3'd5;
    localparam logic [2:0] MSG_BUSY    = 3'd6;

    localparam logic [7:0] BCAST_ADDR  = 8'hFF;

endpackage

// File: rtl/block_list.sv
// ----------------------------------------------------------------------------
// block_list
// Small register CAM holding blocked caller addresses.
//   clk, reset_n   : clock, synchronous active-low reset (empties the list)
//   add, addr_in   : write addr_in into the lowest free entry (caller ensures
//                    the list is not full and addr_in is not already present)
//   clr            : empty the list
//   lookup_addr    : address to test; hit is combinational
//   dup            : addr_in already present (combinational)
//   full           : every entry occupied
// ----------------------------------------------------------------------------
module block_list
    import call_pkg::*;
#(
    parameter int BLK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       add,
    input  logic       clr,
    input  logic [7:0] addr_in,
    input  logic [7:0] lookup_addr,
    output logic       hit,
    output logic       dup,
    output logic       full
);

    logic [BLK_DEPTH-1:0] r_valid;
    logic [7:0]           r_addr [BLK_DEPTH];
    logic [BLK_DEPTH-1:0] w_free_sel;

    assign full = &r_valid;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loops can leave a value unassigned and infer a latch.
    always_comb begin
        hit        = 1'b0;
        dup        = 1'b0;
        w_free_sel = '0;
        // Walk downwards so the lowest free entry is the one left selected.
        for (int i = BLK_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == lookup_addr)) hit = 1'b1;
            if (r_valid[i] && (r_addr[i] == addr_in))     dup = 1'b1;
            if (!r_valid[i]) begin
                w_free_sel    = '0;
                w_free_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (clr) begin
            r_valid <= '0;
        end else if (add) begin
            r_valid <= r_valid | w_free_sel;
        end
    end

    // NOTE: only the valid bits are reset; a stale address behind a cleared
    // valid bit is never matched, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BLK_DEPTH; i++) begin
            if (add && !clr && w_free_sel[i]) r_addr[i] <= addr_in;
        end
    end

endmodule

// File: rtl/call_controller.sv
// ----------------------------------------------------------------------------
// call_controller
// Call-control FSM between the user interface and the packet layer.
//   clk, reset_n            : clock, synchronous active-low reset
//   ui_cmd/_valid, ui_addr  : one-cycle UI command and its dial/block address
//   rx_valid/_type/_src     : received signalling message
//   tx_ready                : packet layer accepts the pending tx message
//   tx_valid/_type/_dest    : single-entry outgoing message register
//   current_state           : call state code for the UI
//   remote_addr             : peer of the active or pending call
//   incoming_call/inc_address : a non-blocked call is ringing, and who from
//   cmd_err                 : one-cycle pulse, command illegal or dropped
// ----------------------------------------------------------------------------
module call_controller
    import call_pkg::*;
#(
    parameter logic [7:0] MY_ADDR      = 8'h01,
    parameter int         RING_TIMEOUT = 1000,
    parameter int         BLK_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] ui_cmd,
    input  logic       ui_cmd_valid,
    input  logic [7:0] ui_addr,
    input  logic       rx_valid,
    input  logic [2:0] rx_type,
    input  logic [7:0] rx_src,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [2:0] tx_type,
    output logic [7:0] tx_dest,
    output logic [2:0] current_state,
    output logic [7:0] remote_addr,
    output logic       incoming_call,
    output logic [7:0] inc_address,
    output logic       cmd_err
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(RING_TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_tx_valid;
    logic [2:0]  r_tx_type;
    logic [7:0]  r_tx_dest;
    logic [7:0]  r_remote;
    logic [7:0]  r_inc_addr;
    logic        r_incoming;
    logic        r_cmd_err;
    logic        r_pend_valid;
    logic [2:0]  r_pend_cmd;
    logic [7:0]  r_pend_addr;

    logic        w_rx;
    logic        w_cmd_valid;
    logic [2:0]  w_cmd;
    logic [7:0]  w_cmd_addr;
    logic        w_cmd_exec;
    logic        w_cmd_legal;
    logic        w_tx_free;
    logic        w_timeout;
    logic        w_blocked;
    logic        w_dup;
    logic        w_full;
    logic        w_blk_add;
    logic        w_blk_clr;

    // Our own messages echoed back by the network are not signalling input.
    assign w_rx        = rx_valid && (rx_src != MY_ADDR);
    // A command deferred behind an rx message takes precedence over a new one.
    assign w_cmd_valid = r_pend_valid || ui_cmd_valid;
    assign w_cmd       = r_pend_valid ? r_pend_cmd  : ui_cmd;
    assign w_cmd_addr  = r_pend_valid ? r_pend_addr : ui_addr;
    assign w_cmd_exec  = w_cmd_valid && !w_rx;
    // The slot is reusable in the same cycle the pending message is taken.
    assign w_tx_free   = !r_tx_valid || tx_ready;
    assign w_timeout   = (r_timer >= TIMEOUT_LAST);
    assign w_blk_add   = w_cmd_exec && (w_cmd == CMD_BLK_ADD) && !w_dup && !w_full;
    assign w_blk_clr   = w_cmd_exec && (w_cmd == CMD_BLK_CLR);

    block_list #(.BLK_DEPTH(BLK_DEPTH)) u_block_list (
        .clk         (clk),
        .reset_n     (reset_n),
        .add         (w_blk_add),
        .clr         (w_blk_clr),
        .addr_in     (w_cmd_addr),
        .lookup_addr (rx_src),
        .hit         (w_blocked),
        .dup         (w_dup),
        .full        (w_full)
    );

    always_comb begin
        w_cmd_legal = 1'b0;
        case (r_state)
            ST_INIT:      w_cmd_legal = (w_cmd == CMD_INIT);
            ST_IDLE:      w_cmd_legal = (w_cmd == CMD_DIAL) && (w_cmd_addr != MY_ADDR);
            ST_OUTGOING,
            ST_BUSY:      w_cmd_legal = (w_cmd == CMD_END);
            ST_INCOMING:  w_cmd_legal = (w_cmd == CMD_ACCEPT) || (w_cmd == CMD_REJECT);
            ST_CALL_WAIT: w_cmd_legal = (w_cmd == CMD_REJECT) || (w_cmd == CMD_END);
            default:      w_cmd_legal = 1'b0;
        endcase
    end

    // Every state entry restarts the ring timer and refreshes incoming_call.
    task automatic enter(input state_t s);
        r_state    <= s;
        r_timer    <= '0;
        r_incoming <= (s == ST_INCOMING) || (s == ST_CALL_WAIT);
    endtask

    task automatic send(input logic [2:0] t, input logic [7:0] d);
        r_tx_valid <= 1'b1;
        r_tx_type  <= t;
        r_tx_dest  <= d;
    endtask

    // Unanswerable rings are refused; with the slot busy the refusal is lost.
    task automatic auto_busy();
        if (w_tx_free) send(MSG_BUSY, rx_src);
    endtask

    // NOTE: all state here is written with non-blocking assignments (tasks
    // included), so later assignments in the block override earlier defaults
    // without any ordering hazard between registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_timer      <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_type    <= '0;
            r_tx_dest    <= '0;
            r_remote     <= '0;
            r_inc_addr   <= '0;
            r_incoming   <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= '0;
            r_pend_addr  <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            if (r_timer != 16'hFFFF) r_timer <= r_timer + 16'd1;
            if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;
            // A fresh command arriving behind a deferred one is lost.
            if (r_pend_valid && ui_cmd_valid) r_cmd_err <= 1'b1;

            if (w_rx) begin
                // The command is re-evaluated next cycle in the resulting state.
                r_pend_valid <= w_cmd_valid;
                r_pend_cmd   <= w_cmd;
                r_pend_addr  <= w_cmd_addr;
                case (r_state)
                    ST_INIT: begin
                        if (rx_type == MSG_INIT)      enter(ST_IDLE);
                        else if (rx_type == MSG_RING) auto_busy();
                    end
                    ST_IDLE: begin
                        if (rx_type == MSG_RING) begin
                            if (w_blocked) begin
                                auto_busy();
                            end else begin
                                r_inc_addr <= rx_src;
                                r_remote   <= rx_src;
                                enter(ST_INCOMING);
                            end
                        end
                    end
                    ST_OUTGOING: begin
                        if (rx_src == r_remote && rx_type == MSG_ACK)
                            enter(ST_BUSY);
                        else if (rx_src == r_remote && (rx_type == MSG_NACK || rx_type == MSG_BUSY))
                            enter(ST_IDLE);
                        else if (rx_type == MSG_RING)
                            auto_busy();
                    end
                    ST_INCOMING: begin
                        if (rx_src == r_inc_addr && rx_type == MSG_HANGUP) enter(ST_IDLE);
                        else if (rx_src != r_inc_addr && rx_type == MSG_RING) auto_busy();
                    end
                    ST_BUSY: begin
                        if (rx_src == r_remote && rx_type == MSG_HANGUP) begin
                            enter(ST_IDLE);
                        end else if (rx_type == MSG_RING) begin
                            if (w_blocked || rx_src == r_remote) begin
                                auto_busy();
                            end else begin
                                r_inc_addr <= rx_src;
                                enter(ST_CALL_WAIT);
                            end
                        end
                    end
                    ST_CALL_WAIT: begin
                        if (rx_src == r_inc_addr && rx_type == MSG_HANGUP) begin
                            enter(ST_BUSY);
                        end else if (rx_src == r_remote && rx_type == MSG_HANGUP) begin
                            r_remote <= r_inc_addr;
                            enter(ST_INCOMING);
                        end else if (rx_src != r_inc_addr && rx_type == MSG_RING) begin
                            auto_busy();
                        end
                    end
                    default: enter(ST_INIT);
                endcase
            end else begin
                r_pend_valid <= 1'b0;
                if (w_cmd_valid) begin
                    case (w_cmd)
                        CMD_NONE, CMD_BLK_CLR: ;
                        CMD_BLK_ADD: if (w_dup || w_full) r_cmd_err <= 1'b1;
                        default: begin
                            if (!w_cmd_legal || !w_tx_free) begin
                                r_cmd_err <= 1'b1;
                            end else begin
                                case (r_state)
                                    ST_INIT: begin
                                        send(MSG_INIT, BCAST_ADDR);
                                        enter(ST_IDLE);
                                    end
                                    ST_IDLE: begin
                                        send(MSG_RING, w_cmd_addr);
                                        r_remote <= w_cmd_addr;
                                        enter(ST_OUTGOING);
                                    end
                                    ST_INCOMING: begin
                                        if (w_cmd == CMD_ACCEPT) begin
                                            send(MSG_ACK, r_inc_addr);
                                            r_remote <= r_inc_addr;
                                            enter(ST_BUSY);
                                        end else begin
                                            send(MSG_NACK, r_inc_addr);
                                            enter(ST_IDLE);
                                        end
                                    end
                                    ST_CALL_WAIT: begin
                                        if (w_cmd == CMD_REJECT) begin
                                            send(MSG_NACK, r_inc_addr);
                                            enter(ST_BUSY);
                                        end else begin
                                            // Drop the old peer, the waiting caller now rings.
                                            send(MSG_HANGUP, r_remote);
                                            r_remote <= r_inc_addr;
                                            enter(ST_INCOMING);
                                        end
                                    end
                                    default: begin
                                        send(MSG_HANGUP, r_remote);
                                        enter(ST_IDLE);
                                    end
                                endcase
                            end
                        end
                    endcase
                end else if (w_timeout) begin
                    case (r_state)
                        ST_OUTGOING, ST_INCOMING: enter(ST_IDLE);
                        ST_CALL_WAIT:             enter(ST_BUSY);
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tx_valid      = r_tx_valid;
    assign tx_type       = r_tx_type;
    assign tx_dest       = r_tx_dest;
    assign current_state = r_state;
    assign remote_addr   = r_remote;
    assign incoming_call = r_incoming;
    assign inc_address   = r_inc_addr;
    assign cmd_err       = r_cmd_err;

endmodule
